// File: rtl/sliding_window.sv
// Streaming KxK window generator: buffers K-1 image rows and emits every
// valid stride-1 window of a raster-order pixel stream with ready/valid on
// both sides and a one-deep output register.
module sliding_window #(
   parameter int unsigned KERNEL_SIZE = 3,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned IMG_WIDTH   = 28,
   parameter int unsigned IMG_HEIGHT  = 28
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic                  pixel_valid,
   output logic                  pixel_ready,
   output logic [DATA_WIDTH-1:0] window [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
   output logic                  window_valid,
   input  logic                  window_ready,
   output logic                  window_last
);

   localparam int unsigned K     = KERNEL_SIZE;
   localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_EMIT = COL_W'(K - 1);
   localparam logic [ROW_W-1:0] ROW_EMIT = ROW_W'(K - 1);

   logic                  accept;
   logic                  emit;
   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [DATA_WIDTH-1:0] window_q [0:K-1][0:K-1];
   logic [DATA_WIDTH-1:0] window_d [0:K-1][0:K-1];
   logic [DATA_WIDTH-1:0] line_mem [0:K-2][0:IMG_WIDTH-1];
   logic [DATA_WIDTH-1:0] line_rd  [0:K-2];

   assign pixel_ready  = !valid_q || window_ready;
   assign accept       = pixel_valid && pixel_ready;
   assign emit         = accept && (row_q >= ROW_EMIT) && (col_q >= COL_EMIT);
   assign window_valid = valid_q;
   assign window_last  = last_q;
   assign window       = window_q;

   // Line buffer read at the current column (buffer 0 = newest row above)
   always_comb begin
      for (int unsigned k = 0; k < K - 1; k++) begin
         line_rd[k] = line_mem[k][col_q];
      end
   end

   // Line buffer cascade: each buffer takes what the one below it just read
   always_ff @(posedge clk) begin
      if (accept) begin
         line_mem[0][col_q] <= pixel_in;
         for (int unsigned k = 1; k < K - 1; k++) begin
            line_mem[k][col_q] <= line_rd[k-1];
         end
      end
   end

   // Raster position counters
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   // Window shift: columns move left, new rightmost column is oldest row on top
   always_comb begin
      window_d = window_q;
      if (accept) begin
         for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K - 1; j++) begin
               window_d[i][j] = window_q[i][j+1];
            end
         end
         for (int unsigned i = 0; i < K - 1; i++) begin
            window_d[i][K-1] = line_rd[K-2-i];
         end
         window_d[K-1][K-1] = pixel_in;
      end
   end

   // Output handshake: consume clears, a same-cycle emitting accept refills
   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      if (valid_q && window_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
      if (emit) begin
         valid_d = 1'b1;
         last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
               window_q[i][j] <= '0;
            end
         end
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         window_q <= window_d;
      end
   end

endmodule

// File: tb/tb_sliding_window.sv
// Bench for sliding_window: two instances (5x5 and 28x28 frames), a
// reference that stores the frame image and cuts windows out of it directly.
module tb_sliding_window;

   localparam int K  = 3;
   localparam int DW = 8;
   localparam int WW = K * K * DW;
   localparam int CW = WW + 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [DW-1:0] px5, px28;
   logic          v5, v28, rdy5, rdy28;
   logic          pr5, pr28, wv5, wv28, wl5, wl28;
   logic [DW-1:0] win5  [0:K-1][0:K-1];
   logic [DW-1:0] win28 [0:K-1][0:K-1];
   logic [WW-1:0] wp5, wp28;

   sliding_window #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
      .clk(clk), .reset(reset), .pixel_in(px5), .pixel_valid(v5), .pixel_ready(pr5),
      .window(win5), .window_valid(wv5), .window_ready(rdy5), .window_last(wl5));

   sliding_window #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut28 (
      .clk(clk), .reset(reset), .pixel_in(px28), .pixel_valid(v28), .pixel_ready(pr28),
      .window(win28), .window_valid(wv28), .window_ready(rdy28), .window_last(wl28));

   always_comb begin
      wp5  = '0;
      wp28 = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            wp5[(i*K+j)*DW +: DW]  = win5[i][j];
            wp28[(i*K+j)*DW +: DW] = win28[i][j];
         end
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit sel = 1'b0;
   int r_m = 0, c_m = 0;
   int first_wv_cyc = 0;
   int t12 = 0;
   logic [DW-1:0] img [0:27][0:27];
   logic [DW-1:0] pix [0:1023];
   logic [WW:0]   expq [$];
   logic [WW:0]   seen [$];
   logic [WW:0]   basic_seen [$];
   logic [WW-1:0] obs_w;
   logic          obs_pr;

   task automatic check(input string tag, input logic [WW:0] obs, input logic [WW:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] mkwin(input int base, input int stride);
      logic [WW-1:0] w;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            w[(i*K+j)*DW +: DW] = DW'(base + i*stride + j);
      return w;
   endfunction

   task automatic model_reset();
      expq.delete();
      r_m = 0;
      c_m = 0;
   endtask

   // One clock: drive at negedge, observe 1 time unit later, update the model
   task automatic cycle(input bit v, input logic [DW-1:0] px, input bit rdy, output bit acc);
      logic [WW-1:0] w;
      logic [WW:0]   e;
      logic wv, wl, pr;
      int dim;
      @(negedge clk);
      if (sel) begin
         v28 = v; px28 = px; rdy28 = rdy; v5 = 1'b0; rdy5 = 1'b1;
      end else begin
         v5 = v; px5 = px; rdy5 = rdy; v28 = 1'b0; rdy28 = 1'b1;
      end
      #1;
      cyc++;
      if (sel) begin wv = wv28; wl = wl28; pr = pr28; w = wp28; dim = 28; end
      else     begin wv = wv5;  wl = wl5;  pr = pr5;  w = wp5;  dim = 5;  end
      obs_w  = w;
      obs_pr = pr;
      check("window_valid", CW'(wv), CW'(expq.size() != 0));
      check("pixel_ready", CW'(pr), CW'((expq.size() == 0) || rdy));
      if (wv && first_wv_cyc == 0) first_wv_cyc = cyc;
      if (wv && rdy) begin
         seen.push_back({wl, w});
         if (expq.size() != 0) check("window_data", {wl, w}, expq.pop_front());
      end
      acc = v && pr;
      if (acc) begin
         img[r_m][c_m] = px;
         if (r_m >= K-1 && c_m >= K-1) begin
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  e[(i*K+j)*DW +: DW] = img[r_m-K+1+i][c_m-K+1+j];
            e[WW] = (r_m == dim-1) && (c_m == dim-1);
            expq.push_back(e);
         end
         c_m++;
         if (c_m == dim) begin
            c_m = 0;
            r_m++;
            if (r_m == dim) r_m = 0;
         end
      end
   endtask

   task automatic send(input int start, input int n, input int vp, input int rp);
      int idx = start;
      int budget = 0;
      bit acc;
      while (idx < n && budget < 20000) begin
         cycle($urandom_range(99) < vp, pix[idx], $urandom_range(99) < rp, acc);
         if (acc) begin
            if (idx == 12) t12 = cyc;
            idx++;
         end
         budget++;
      end
      check("send_complete", CW'(idx), CW'(n));
   endtask

   task automatic drain();
      bit acc;
      repeat (4) cycle(1'b0, '0, 1'b1, acc);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int lasts;
      reset = 1'b1;
      v5 = 1'b0; v28 = 1'b0; rdy5 = 1'b1; rdy28 = 1'b1; px5 = '0; px28 = '0;
      #12;
      check("rst_valid5", CW'(wv5), CW'(0));
      check("rst_last5", CW'(wl5), CW'(0));
      check("rst_ready5", CW'(pr5), CW'(1));
      check("rst_window5", CW'(wp5), CW'(0));
      check("rst_window28", CW'(wp28), CW'(0));
      check("rst_ready28", CW'(pr28), CW'(1));
      @(negedge clk);
      reset = 1'b0;

      // Basic 5x5 frame, always ready
      sel = 1'b0;
      for (int i = 0; i < 25; i++) pix[i] = DW'(i);
      seen.delete(); first_wv_cyc = 0;
      send(0, 25, 100, 100);
      drain();
      check("basic_latency", CW'(first_wv_cyc - t12), CW'(1));
      check("basic_count", CW'(seen.size()), CW'(9));
      check("basic_first", seen[0], {1'b0, mkwin(0, 5)});
      check("basic_last", seen[8], {1'b1, mkwin(12, 5)});
      basic_seen = seen;

      // Back-pressure on the second window
      seen.delete();
      send(0, 14, 100, 100);
      for (int s = 0; s < 4; s++) begin
         cycle(1'b1, pix[14], 1'b0, acc);
         check("stall_window", CW'(obs_w), CW'(mkwin(1, 5)));
         check("stall_ready", CW'(obs_pr), CW'(0));
      end
      send(14, 25, 100, 100);
      drain();
      check("bp_count", CW'(seen.size()), CW'(9));
      check("bp_held", seen[1], {1'b0, mkwin(1, 5)});
      check("bp_next", seen[2], {1'b0, mkwin(2, 5)});

      // Random gaps on both sides over a 28x28 frame
      sel = 1'b1;
      seen.delete();
      for (int i = 0; i < 784; i++) pix[i] = DW'($urandom);
      send(0, 784, 70, 60);
      drain();
      check("rand_count", CW'(seen.size()), CW'(676));
      lasts = 0;
      foreach (seen[i]) if (seen[i][WW]) lasts++;
      check("rand_last_count", CW'(lasts), CW'(1));
      if (seen.size() == 676) check("rand_last_flag", CW'(seen[675][WW]), CW'(1));

      // Two back-to-back 5x5 frames
      sel = 1'b0;
      seen.delete();
      for (int i = 0; i < 25; i++) begin
         pix[i]    = DW'(i);
         pix[25+i] = DW'(100 + i);
      end
      send(0, 50, 100, 100);
      drain();
      check("b2b_count", CW'(seen.size()), CW'(18));
      check("b2b_f1_last", seen[8], {1'b1, mkwin(12, 5)});
      check("b2b_f2_first", seen[9], {1'b0, mkwin(100, 5)});

      // Mid-frame reset after 8 pixels, then a full basic frame
      for (int i = 0; i < 25; i++) pix[i] = DW'(i);
      send(0, 8, 100, 100);
      @(negedge clk);
      v5 = 1'b0; v28 = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_valid", CW'(wv5), CW'(0));
      check("mid_rst_last", CW'(wl5), CW'(0));
      check("mid_rst_ready", CW'(pr5), CW'(1));
      check("mid_rst_window", CW'(wp5), CW'(0));
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      seen.delete();
      send(0, 25, 100, 100);
      drain();
      check("rst_frame_count", CW'(seen.size()), CW'(basic_seen.size()));
      for (int i = 0; i < seen.size() && i < basic_seen.size(); i++)
         check("rst_frame_window", seen[i], basic_seen[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
